peripheral_mpram_ahb3_master: RTL and testbench
===============================================

PERIPHERAL_MPRAM_AHB3_MASTER -- requirements
Module: peripheral_mpram_ahb3_master

Interface
REQ-001 SHALL have parameter PLEN, default 64, address width.
REQ-002 SHALL have parameter XLEN, default 64, data width.
REQ-003 SHALL have parameter HPROT_VAL, default 4'b0011, constant HPROT value.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL provide ports, one per line:
  HCLK  in  1  clock, rising edge
  HRESETn  in  1  async active-low reset
  req_valid_i  in  1  request offered
  req_ready_o  out  1  request accepted when valid&ready
  req_we_i  in  1  1=write, 0=read
  req_addr_i  in  PLEN  byte address
  req_size_i  in  3  AHB HSIZE encoding
  req_wdata_i  in  XLEN  write data, bus-lane aligned
  rsp_valid_o  out  1  one-cycle completion pulse
  rsp_rdata_o  out  XLEN  read data (raw HRDATA lanes)
  rsp_err_o  out  1  completion was ERROR
  HSEL  out  1  slave select
  HADDR  out  PLEN  address phase address
  HWDATA  out  XLEN  data phase write data
  HRDATA  in  XLEN  read data
  HWRITE  out  1  transfer direction
  HSIZE  out  3  transfer size
  HBURST  out  3  constant SINGLE (3'b000)
  HPROT  out  4  constant HPROT_VAL
  HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only
  HMASTLOCK  out  1  constant 0
  HREADY  in  1  slave HREADYOUT
  HRESP  in  1  0=OKAY, 1=ERROR

Function
REQ-006 SHALL hold a two-stage pipeline: address slot (a_vld, we, addr, size, wdata) and data slot (d_vld, we, wdata); state = {a_vld, d_vld, err_q}.
REQ-007 SHALL drive HTRANS=NONSEQ and HSEL=1 iff a_vld and not err_q, else IDLE/0; HADDR/HWRITE/HSIZE from address slot, all registered.
REQ-008 SHALL set req_ready_o = ~err_q & (~a_vld | HREADY); accepted request loads address slot next edge.
REQ-009 SHALL advance address slot to data slot on edge where a_vld & HREADY & ~err_q; address slot then reloads from input if accepted, else clears.
REQ-010 SHALL drive HWDATA from data slot for whole data phase, held stable while HREADY=0.
REQ-011 SHALL retire data slot on edge with d_vld & HREADY: next cycle rsp_valid_o=1, rsp_rdata_o=HRDATA (reads; 0 for writes), rsp_err_o=HRESP.
REQ-012 SHALL allow back-to-back transfers: one completion per cycle when HREADY stays 1, single-cycle latency from address phase to data phase.
REQ-013 SHALL on first ERROR cycle (d_vld & HRESP & ~HREADY) set err_q, forcing HTRANS=IDLE next cycle while pending address slot is held, not dropped.
REQ-014 SHALL clear err_q on the second ERROR cycle (HRESP & HREADY), then re-issue the held address slot as NONSEQ the following cycle.
REQ-015 SHALL never change HADDR/HWRITE/HSIZE of an issued NONSEQ while HREADY=0 except via REQ-013.
REQ-016 SHALL treat rsp path as always accepting; no backpressure on rsp_*.

Reset
REQ-017 SHALL on HRESETn=0 immediately clear a_vld, d_vld, err_q and force HSEL=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0; req_ready_o=1 after release; in-flight transfers discarded with no response.

Verification
REQ-018 Write 0x40, size 3, data 0x1122334455667788, HREADY=1 -> NONSEQ cycle N, HWDATA valid N+1, rsp_valid=1 err=0 at N+2.
REQ-019 Four back-to-back reads 0x0,0x8,0x10,0x18, HREADY=1 -> four consecutive NONSEQ cycles, four consecutive rsp pulses with HRDATA values in order.
REQ-020 Read with HREADY=0 for 3 cycles -> HADDR/HTRANS of next request and req_ready_o=0 held stable, rsp after HREADY returns.
REQ-021 Write then read, slave ERROR on write -> HTRANS=IDLE in second error cycle, rsp_err=1 for write, read re-issued and completes err=0.
REQ-022 HRESETn low during data phase -> outputs at reset values same cycle, no rsp_valid pulse, next request proceeds normally.

Source files
------------

// File: rtl/peripheral_mpram_ahb3_master.sv
// AHB3-Lite single-transfer master with a two-slot (address/data) pipeline.
// Ports: req_* request in, rsp_* completion out, H* AHB3-Lite master bus.
module peripheral_mpram_ahb3_master #(
   parameter int         PLEN      = 64,
   parameter int         XLEN      = 64,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [PLEN-1:0] req_addr_i,
   input  logic [2:0]      req_size_i,
   input  logic [XLEN-1:0] req_wdata_i,
   output logic            rsp_valid_o,
   output logic [XLEN-1:0] rsp_rdata_o,
   output logic            rsp_err_o,
   output logic            HSEL,
   output logic [PLEN-1:0] HADDR,
   output logic [XLEN-1:0] HWDATA,
   input  logic [XLEN-1:0] HRDATA,
   output logic            HWRITE,
   output logic [2:0]      HSIZE,
   output logic [2:0]      HBURST,
   output logic [3:0]      HPROT,
   output logic [1:0]      HTRANS,
   output logic            HMASTLOCK,
   input  logic            HREADY,
   input  logic            HRESP
);

   // address slot
   logic            a_vld_q, a_vld_d;
   logic            a_we_q, a_we_d;
   logic [PLEN-1:0] a_addr_q, a_addr_d;
   logic [2:0]      a_size_q, a_size_d;
   logic [XLEN-1:0] a_wdata_q, a_wdata_d;

   // data slot
   logic            d_vld_q, d_vld_d;
   logic            d_we_q, d_we_d;
   logic [XLEN-1:0] d_wdata_q, d_wdata_d;

   // error tracking and completion
   logic            err_q, err_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q, rsp_err_d;

   logic accept;
   logic advance;
   logic retire;

   always_comb begin
      req_ready_o = ~err_q & (~a_vld_q | HREADY);
      accept      = req_valid_i & req_ready_o;
      advance     = a_vld_q & HREADY & ~err_q;
      retire      = d_vld_q & HREADY;

      a_vld_d   = a_vld_q;
      a_we_d    = a_we_q;
      a_addr_d  = a_addr_q;
      a_size_d  = a_size_q;
      a_wdata_d = a_wdata_q;
      if (accept) begin
         a_vld_d   = 1'b1;
         a_we_d    = req_we_i;
         a_addr_d  = req_addr_i;
         a_size_d  = req_size_i;
         a_wdata_d = req_wdata_i;
      end else if (advance) begin
         a_vld_d = 1'b0;
      end

      d_vld_d   = d_vld_q;
      d_we_d    = d_we_q;
      d_wdata_d = d_wdata_q;
      if (advance) begin
         d_vld_d   = 1'b1;
         d_we_d    = a_we_q;
         d_wdata_d = a_wdata_q;
      end else if (retire) begin
         d_vld_d = 1'b0;
      end

      // Two-cycle ERROR: the first cycle (HREADY low) arms err_q so the
      // pending address phase drops to IDLE; the second cycle clears it.
      if (err_q) begin
         err_d = ~HREADY;
      end else begin
         err_d = d_vld_q & HRESP & ~HREADY;
      end

      rsp_valid_d = retire;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (retire) begin
         rsp_rdata_d = d_we_q ? '0 : HRDATA;
         rsp_err_d   = HRESP;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_vld_q     <= 1'b0;
         a_we_q      <= 1'b0;
         a_addr_q    <= '0;
         a_size_q    <= '0;
         a_wdata_q   <= '0;
         d_vld_q     <= 1'b0;
         d_we_q      <= 1'b0;
         d_wdata_q   <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         a_vld_q     <= a_vld_d;
         a_we_q      <= a_we_d;
         a_addr_q    <= a_addr_d;
         a_size_q    <= a_size_d;
         a_wdata_q   <= a_wdata_d;
         d_vld_q     <= d_vld_d;
         d_we_q      <= d_we_d;
         d_wdata_q   <= d_wdata_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign HSEL      = a_vld_q & ~err_q;
   assign HTRANS    = (a_vld_q & ~err_q) ? 2'b10 : 2'b00;
   assign HADDR     = a_addr_q;
   assign HWRITE    = a_we_q;
   assign HSIZE     = a_size_q;
   assign HWDATA    = d_wdata_q;
   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_peripheral_mpram_ahb3_master.sv
// Scoreboard bench for peripheral_mpram_ahb3_master.
// Directed stimulus; a negedge monitor pops expected completions.
module tb_peripheral_mpram_ahb3_master;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [63:0] req_addr_i = '0;
   logic [2:0]  req_size_i = '0;
   logic [63:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic [63:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        HSEL;
   logic [63:0] HADDR;
   logic [63:0] HWDATA;
   logic [63:0] HRDATA;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HMASTLOCK;
   logic        HREADY = 1'b1;
   logic        HRESP = 1'b0;

   peripheral_mpram_ahb3_master dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_size_i  (req_size_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .HSEL        (HSEL),
      .HADDR       (HADDR),
      .HWDATA      (HWDATA),
      .HRDATA      (HRDATA),
      .HWRITE      (HWRITE),
      .HSIZE       (HSIZE),
      .HBURST      (HBURST),
      .HPROT       (HPROT),
      .HTRANS      (HTRANS),
      .HMASTLOCK   (HMASTLOCK),
      .HREADY      (HREADY),
      .HRESP       (HRESP)
   );

   always #5 HCLK = ~HCLK;

   // slave: read data = A5A5 tag in top bits | data-phase address
   logic [63:0] dph_addr = '0;
   always @(posedge HCLK) begin
      if (HTRANS == 2'b10 && HREADY) dph_addr <= HADDR;
   end
   assign HRDATA = 64'hA5A5_0000_0000_0000 | dph_addr;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   rsp_cnt = 0;
   int   rsp_cyc[$];

   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [63:0] rd, input logic er);
      exp_t e;
      e.rdata = rd;
      e.err   = er;
      sb.push_back(e);
   endtask

   always @(negedge HCLK) begin
      if (HRESETn && rsp_valid_o) begin
         rsp_cnt++;
         rsp_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got data %h err %b want none",
                     rsp_rdata_o, rsp_err_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata_o, e.rdata);
            chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, e.err});
         end
      end
   end

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic set_req(input logic v, input logic we,
                          input logic [63:0] a, input logic [63:0] wd);
      req_valid_i = v;
      req_we_i    = we;
      req_addr_i  = a;
      req_size_i  = 3'd3;
      req_wdata_i = wd;
   endtask

   int snap;
   int n;

   initial begin
      // reset
      step();
      step();
      #1;
      chk("rst_htrans", {62'd0, HTRANS}, 64'd0);
      chk("rst_hsel", {63'd0, HSEL}, 64'd0);
      chk("rst_haddr", HADDR, 64'd0);
      chk("rst_hwdata", HWDATA, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
      chk("const_hburst", {61'd0, HBURST}, 64'd0);
      chk("const_hprot", {60'd0, HPROT}, 64'd3);
      chk("const_hlock", {63'd0, HMASTLOCK}, 64'd0);
      step();
      HRESETn = 1'b1;
      #1;
      chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
      step();

      // single write
      set_req(1'b1, 1'b1, 64'h40, 64'h1122334455667788);
      push(64'd0, 1'b0);
      step();
      set_req(1'b0, 1'b0, 64'd0, 64'd0);
      #1;
      chk("wr_htrans_n", {62'd0, HTRANS}, 64'd2);
      chk("wr_hsel_n", {63'd0, HSEL}, 64'd1);
      chk("wr_haddr_n", HADDR, 64'h40);
      chk("wr_hwrite_n", {63'd0, HWRITE}, 64'd1);
      chk("wr_hsize_n", {61'd0, HSIZE}, 64'd3);
      step();
      #1;
      chk("wr_htrans_n1", {62'd0, HTRANS}, 64'd0);
      chk("wr_hwdata_n1", HWDATA, 64'h1122334455667788);
      chk("wr_rsp_n1", {63'd0, rsp_valid_o}, 64'd0);
      step();
      #1;
      chk("wr_rsp_n2", {63'd0, rsp_valid_o}, 64'd1);
      step();
      step();

      // four back-to-back reads
      push(64'hA5A5000000000000, 1'b0);
      push(64'hA5A5000000000008, 1'b0);
      push(64'hA5A5000000000010, 1'b0);
      push(64'hA5A5000000000018, 1'b0);
      for (int i = 0; i < 4; i++) begin
         set_req(1'b1, 1'b0, 64'(i * 8), 64'd0);
         #1;
         if (i > 0) begin
            chk("b2b_htrans", {62'd0, HTRANS}, 64'd2);
            chk("b2b_haddr", HADDR, 64'((i - 1) * 8));
         end
         step();
      end
      set_req(1'b0, 1'b0, 64'd0, 64'd0);
      #1;
      chk("b2b_haddr_last", HADDR, 64'h18);
      repeat (5) step();
      n = rsp_cyc.size();
      chk("b2b_rsp_cnt", 64'(n), 64'd5);
      for (int i = n - 3; i < n; i++) begin
         chk("b2b_rsp_consec", 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'd1);
      end

      // wait states
      push(64'hA5A5000000000080, 1'b0);
      push(64'hA5A5000000000088, 1'b0);
      push(64'hA5A5000000000090, 1'b0);
      set_req(1'b1, 1'b0, 64'h80, 64'd0);
      step();
      set_req(1'b1, 1'b0, 64'h88, 64'd0);
      step();
      set_req(1'b1, 1'b0, 64'h90, 64'd0);
      HREADY = 1'b0;
      snap = rsp_cnt;
      for (int i = 0; i < 3; i++) begin
         HREADY = 1'b0;
         #1;
         chk("ws_ready", {63'd0, req_ready_o}, 64'd0);
         chk("ws_htrans", {62'd0, HTRANS}, 64'd2);
         chk("ws_haddr", HADDR, 64'h88);
         step();
      end
      HREADY = 1'b1;
      #1;
      chk("ws_ready_back", {63'd0, req_ready_o}, 64'd1);
      chk("ws_no_rsp", 64'(rsp_cnt - snap), 64'd0);
      step();
      set_req(1'b0, 1'b0, 64'd0, 64'd0);
      repeat (5) step();

      // ERROR on write, read re-issued
      push(64'd0, 1'b1);
      push(64'hA5A5000000000108, 1'b0);
      set_req(1'b1, 1'b1, 64'h100, 64'h0BADF00D);
      step();
      set_req(1'b1, 1'b0, 64'h108, 64'd0);
      step();
      set_req(1'b0, 1'b0, 64'd0, 64'd0);
      HREADY = 1'b0;
      HRESP  = 1'b1;
      #1;
      chk("err1_htrans", {62'd0, HTRANS}, 64'd2);
      chk("err1_haddr", HADDR, 64'h108);
      step();
      HREADY = 1'b1;
      HRESP  = 1'b1;
      #1;
      chk("err2_htrans", {62'd0, HTRANS}, 64'd0);
      chk("err2_hsel", {63'd0, HSEL}, 64'd0);
      chk("err2_ready", {63'd0, req_ready_o}, 64'd0);
      step();
      HRESP = 1'b0;
      #1;
      chk("reissue_htrans", {62'd0, HTRANS}, 64'd2);
      chk("reissue_haddr", HADDR, 64'h108);
      chk("reissue_hwrite", {63'd0, HWRITE}, 64'd0);
      chk("err_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
      chk("err_rsp_err", {63'd0, rsp_err_o}, 64'd1);
      repeat (5) step();

      // reset during data phase
      set_req(1'b1, 1'b1, 64'h200, 64'hDEADBEEFCAFEF00D);
      step();
      set_req(1'b0, 1'b0, 64'd0, 64'd0);
      step();
      chk("rst_dph_hwdata", HWDATA, 64'hDEADBEEFCAFEF00D);
      snap = rsp_cnt;
      HRESETn = 1'b0;
      #1;
      chk("rst_mid_htrans", {62'd0, HTRANS}, 64'd0);
      chk("rst_mid_haddr", HADDR, 64'd0);
      chk("rst_mid_hwdata", HWDATA, 64'd0);
      chk("rst_mid_hsel", {63'd0, HSEL}, 64'd0);
      chk("rst_mid_rsp", {63'd0, rsp_valid_o}, 64'd0);
      step();
      step();
      HRESETn = 1'b1;
      #1;
      chk("rst_mid_ready", {63'd0, req_ready_o}, 64'd1);
      step();
      step();
      chk("rst_mid_no_rsp", 64'(rsp_cnt - snap), 64'd0);
      push(64'hA5A5000000000208, 1'b0);
      set_req(1'b1, 1'b0, 64'h208, 64'd0);
      step();
      set_req(1'b0, 1'b0, 64'd0, 64'd0);

      // drain, bounded
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      step();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
